door_lock_ctrl: RTL

Sequencing controller for the door security system's code-entry path. It frames a keypad bit stream into fixed-length code attempts, compares each completed attempt against a stored code, drives the door-open strobe for a fixed hold time, and enforces an alarm lockout after repeated failures. It sits between the keypad front end and the door actuator/alarm drivers, and owns the `enter` sequencing that starts each attempt.

---
 rtl/door_lock_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/door_lock_ctrl.sv
// rtl/door_lock_ctrl.sv - keypad code-entry sequencer with door-open hold and alarm lockout
module door_lock_ctrl #(
    parameter int                  CODE_LEN      = 4,
    parameter logic [CODE_LEN-1:0] CODE          = 4'b1011,
    parameter int                  MAX_FAIL      = 3,
    parameter int                  UNLOCK_CYCLES = 8,
    parameter int                  LOCK_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enter,
    input  logic       key_vld,
    input  logic       key_bit,
    output logic       door_open,
    output logic       alarm,
    output logic       entry_active,
    output logic       bad_code,
    output logic [1:0] fail_cnt
);

    localparam logic [3:0] LAST_BIT = 4'(CODE_LEN - 1);
    localparam logic [7:0] UNLOCK_T = 8'(UNLOCK_CYCLES);
    localparam logic [7:0] LOCK_T   = 8'(LOCK_CYCLES);
    localparam logic [1:0] FAIL_LIM = 2'(MAX_FAIL);

    typedef enum logic [1:0] {IDLE, ENTRY, OPEN, LOCKOUT} state_t;

    state_t              state, state_n;
    logic [CODE_LEN-2:0] shift, shift_n;
    logic [3:0]          bit_cnt, bit_cnt_n;
    logic [7:0]          timer, timer_n;
    logic [1:0]          fail_n;
    logic [1:0]          fail_inc;
    logic                bad_n;
    logic [CODE_LEN-1:0] attempt;

    // The completing key is compared directly, so only CODE_LEN-1 bits are stored.
    assign attempt  = {shift, key_bit};
    assign fail_inc = fail_cnt + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shift        <= '0;
            bit_cnt      <= '0;
            timer        <= '0;
            fail_cnt     <= '0;
            door_open    <= 1'b0;
            alarm        <= 1'b0;
            entry_active <= 1'b0;
            bad_code     <= 1'b0;
        end else begin
            state        <= state_n;
            shift        <= shift_n;
            bit_cnt      <= bit_cnt_n;
            timer        <= timer_n;
            fail_cnt     <= fail_n;
            door_open    <= (state_n == OPEN);
            alarm        <= (state_n == LOCKOUT);
            entry_active <= (state_n == ENTRY);
            bad_code     <= bad_n;
        end
    end

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        timer_n   = timer;
        fail_n    = fail_cnt;
        bad_n     = 1'b0;
        case (state)
            IDLE: begin
                if (enter) begin
                    state_n   = ENTRY;
                    shift_n   = '0;
                    bit_cnt_n = '0;
                end
            end
            ENTRY: begin
                // enter wins over a coincident key: the attempt restarts empty.
                if (enter) begin
                    shift_n   = '0;
                    bit_cnt_n = '0;
                end else if (key_vld) begin
                    shift_n   = attempt[CODE_LEN-2:0];
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n = '0;
                        if (attempt == CODE) begin
                            state_n = OPEN;
                            timer_n = UNLOCK_T;
                            fail_n  = '0;
                        end else begin
                            bad_n = 1'b1;
                            if (fail_inc >= FAIL_LIM) begin
                                fail_n  = FAIL_LIM;
                                state_n = LOCKOUT;
                                timer_n = LOCK_T;
                            end else begin
                                fail_n  = fail_inc;
                                state_n = IDLE;
                            end
                        end
                    end
                end
            end
            OPEN: begin
                timer_n = timer - 8'd1;
                if (timer == 8'd1) begin
                    state_n = IDLE;
                end
            end
            LOCKOUT: begin
                timer_n = timer - 8'd1;
                if (timer == 8'd1) begin
                    state_n = IDLE;
                    fail_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
